// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer
//  Description : Blackjack round controller. Owns the card deck handshake and
//                sequences clear, initial deal (P,D,P,D), player turn, dealer
//                turn and settle. Every draw is req/valid, load, settle.
//                Optional natural-blackjack shortcut: NATURAL_BLACKJACK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module round_sequencer #(
  parameter int HAND_W       = 5,
  parameter int BUST_LIMIT   = 21,
  parameter int DEALER_STAND = 17,
  parameter int MAX_CARDS    = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_playerHit,
  input  logic              i_playerStand,
  input  logic [HAND_W-1:0] i_playerHandSum,
  input  logic [HAND_W-1:0] i_dealerHandSum,
  input  logic [2:0]        i_playerCount,
  input  logic [2:0]        i_dealerCount,
  output logic              o_deckReq,
  input  logic              i_deckValid,
  output logic              o_handClear,
  output logic              o_playerLoad,
  output logic              o_dealerLoad,
  output logic [1:0]        o_turn,
  output logic [2:0]        o_gameState,
  output logic [1:0]        o_result
);

  // Thresholds sized to the sum / count buses so comparisons stay unsigned
  localparam logic [HAND_W-1:0] c_bust_sum  = HAND_W'(BUST_LIMIT);
  localparam logic [HAND_W-1:0] c_stand_sum = HAND_W'(DEALER_STAND);
  localparam logic [2:0]        c_max_cnt   = 3'(MAX_CARDS);
`ifdef NATURAL_BLACKJACK_EN
  localparam logic [HAND_W-1:0] c_natural_sum = HAND_W'(21);
  localparam logic [2:0]        c_natural_cnt = 3'd2;
`endif

  localparam logic [1:0] c_res_none   = 2'd0;
  localparam logic [1:0] c_res_player = 2'd1;
  localparam logic [1:0] c_res_dealer = 2'd2;
  localparam logic [1:0] c_res_push   = 2'd3;

  localparam logic [1:0] c_turn_none   = 2'd0;
  localparam logic [1:0] c_turn_player = 2'd1;
  localparam logic [1:0] c_turn_dealer = 2'd2;

  localparam logic [2:0] c_gs_idle   = 3'd0;
  localparam logic [2:0] c_gs_deal   = 3'd1;
  localparam logic [2:0] c_gs_player = 3'd2;
  localparam logic [2:0] c_gs_dealer = 3'd3;
  localparam logic [2:0] c_gs_result = 3'd4;

  // The three draw states (REQ/LOAD/SETTLE) are shared by every phase;
  // r_phase remembers who the draw belongs to and where to return.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_REQ,
    ST_LOAD,
    ST_SETTLE,
    ST_PLAYER,
    ST_DEALER,
    ST_RESULT
  } state_t;

  typedef enum logic [1:0] {
    PH_DEAL,
    PH_PLAYER,
    PH_DEALER
  } phase_t;

  state_t     r_state;
  state_t     w_next_state;
  phase_t     r_phase;
  phase_t     w_next_phase;
  logic [1:0] r_deal_cnt;
  logic [1:0] w_next_deal_cnt;
  logic [1:0] r_result;
  logic [1:0] w_next_result;
  logic       w_target_player;
  logic       w_player_bust;

  // Final outcome once both hands are frozen; player bust is checked first
  function automatic logic [1:0] outcome(input logic [HAND_W-1:0] psum,
                                         input logic [HAND_W-1:0] dsum);
    logic [1:0] res;
    if (psum > c_bust_sum)      res = c_res_dealer;
    else if (dsum > c_bust_sum) res = c_res_player;
    else if (psum > dsum)       res = c_res_player;
    else if (dsum > psum)       res = c_res_dealer;
    else                        res = c_res_push;
    return res;
  endfunction

  // Deal alternates P,D,P,D on the low counter bit; player turn draws to player
  assign w_target_player = (r_phase == PH_PLAYER) ||
                           ((r_phase == PH_DEAL) && (r_deal_cnt[0] == 1'b0));

  assign w_player_bust = (i_playerHandSum > c_bust_sum);

  // State, phase, deal counter and result registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_DEAL;
      r_deal_cnt <= 2'd0;
      r_result   <= c_res_none;
    end else begin
      r_state    <= w_next_state;
      r_phase    <= w_next_phase;
      r_deal_cnt <= w_next_deal_cnt;
      r_result   <= w_next_result;
    end
  end

  // Next-state decode and Moore outputs
  always_comb begin
    w_next_state    = r_state;
    w_next_phase    = r_phase;
    w_next_deal_cnt = r_deal_cnt;
    w_next_result   = r_result;
    o_deckReq       = 1'b0;
    o_handClear     = 1'b0;
    o_playerLoad    = 1'b0;
    o_dealerLoad    = 1'b0;
    o_turn          = c_turn_none;
    o_gameState     = c_gs_idle;

    case (r_state)
      ST_IDLE: begin
        o_gameState = c_gs_idle;
        if (i_start) begin
          w_next_state    = ST_CLEAR;
          w_next_phase    = PH_DEAL;
          w_next_deal_cnt = 2'd0;
          w_next_result   = c_res_none;
        end
      end

      ST_RESULT: begin
        o_gameState = c_gs_result;
        if (i_start) begin
          w_next_state    = ST_CLEAR;
          w_next_phase    = PH_DEAL;
          w_next_deal_cnt = 2'd0;
          w_next_result   = c_res_none;
        end
      end

      ST_CLEAR: begin
        o_gameState  = c_gs_deal;
        o_handClear  = 1'b1;
        w_next_state = ST_REQ;
      end

      // Request stays high until the deck presents a card
      ST_REQ: begin
        o_deckReq = 1'b1;
        if (i_deckValid) w_next_state = ST_LOAD;
      end

      // Exactly one hand latches the accepted card
      ST_LOAD: begin
        o_playerLoad = w_target_player;
        o_dealerLoad = !w_target_player;
        w_next_state = ST_SETTLE;
        if (r_phase == PH_DEAL) w_next_deal_cnt = r_deal_cnt + 2'd1;
      end

      // Sums are valid here for the first time after the load
      ST_SETTLE: begin
        case (r_phase)
          PH_DEAL: begin
            if (r_deal_cnt != 2'd0) begin
              w_next_state = ST_REQ;
            end else begin
`ifdef NATURAL_BLACKJACK_EN
              if ((i_playerHandSum == c_natural_sum) && (i_playerCount == c_natural_cnt)) begin
                w_next_state  = ST_RESULT;
                w_next_result = ((i_dealerHandSum == c_natural_sum) &&
                                 (i_dealerCount == c_natural_cnt)) ? c_res_push : c_res_player;
              end else begin
                w_next_state = ST_PLAYER;
                w_next_phase = PH_PLAYER;
              end
`else
              w_next_state = ST_PLAYER;
              w_next_phase = PH_PLAYER;
`endif
            end
          end
          PH_PLAYER: begin
            if (w_player_bust) begin
              w_next_state  = ST_RESULT;
              w_next_result = c_res_dealer;
            end else begin
              w_next_state = ST_PLAYER;
            end
          end
          default: begin
            w_next_state = ST_DEALER;
          end
        endcase
      end

      // Stand beats hit; a hit into a full hand is a stand
      ST_PLAYER: begin
        if (i_playerStand) begin
          w_next_state = ST_DEALER;
          w_next_phase = PH_DEALER;
        end else if (i_playerHit) begin
          if (i_playerCount >= c_max_cnt) begin
            w_next_state = ST_DEALER;
            w_next_phase = PH_DEALER;
          end else begin
            w_next_state = ST_REQ;
          end
        end
      end

      // Dealer draws autonomously below the stand threshold with room in hand
      ST_DEALER: begin
        if ((i_dealerHandSum < c_stand_sum) && (i_dealerCount < c_max_cnt)) begin
          w_next_state = ST_REQ;
        end else begin
          w_next_state  = ST_RESULT;
          w_next_result = outcome(i_playerHandSum, i_dealerHandSum);
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Game state and turn for the shared draw states follow the phase
    case (r_state)
      ST_REQ, ST_LOAD, ST_SETTLE: begin
        case (r_phase)
          PH_PLAYER: begin
            o_gameState = c_gs_player;
            o_turn      = c_turn_player;
          end
          PH_DEALER: begin
            o_gameState = c_gs_dealer;
            o_turn      = c_turn_dealer;
          end
          default: begin
            o_gameState = c_gs_deal;
            o_turn      = c_turn_none;
          end
        endcase
      end
      ST_PLAYER: begin
        o_gameState = c_gs_player;
        o_turn      = c_turn_player;
      end
      ST_DEALER: begin
        o_gameState = c_gs_dealer;
        o_turn      = c_turn_dealer;
      end
      default: begin
        o_turn = c_turn_none;
      end
    endcase
  end

  assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_sequencer
//  Description : Directed bench for round_sequencer with a card-list deck and
//                a simple summing hand model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_round_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       hit;
  logic       stand;
  logic [4:0] p_sum;
  logic [4:0] d_sum;
  logic [2:0] p_cnt;
  logic [2:0] d_cnt;
  logic       deck_req;
  logic       deck_valid;
  logic       stray_valid;
  logic       deck_valid_in;
  logic       hand_clear;
  logic       p_load;
  logic       d_load;
  logic [1:0] turn;
  logic [2:0] game_state;
  logic [1:0] result;

  int         checks;
  int         failures;
  int         deck_delay;
  int         wait_cnt;
  int         req_run;
  int         last_req_len;
  int         p_loads;
  int         d_loads;
  int         clears;
  int         overlap;
  logic [31:0] ev_log;
  logic [4:0] cards[$];

  assign deck_valid_in = deck_valid | stray_valid;

  round_sequencer dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_start         (start),
    .i_playerHit     (hit),
    .i_playerStand   (stand),
    .i_playerHandSum (p_sum),
    .i_dealerHandSum (d_sum),
    .i_playerCount   (p_cnt),
    .i_dealerCount   (d_cnt),
    .o_deckReq       (deck_req),
    .i_deckValid     (deck_valid_in),
    .o_handClear     (hand_clear),
    .o_playerLoad    (p_load),
    .o_dealerLoad    (d_load),
    .o_turn          (turn),
    .o_gameState     (game_state),
    .o_result        (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hand model and deck responder, evaluated mid-cycle on DUT outputs
  always @(negedge clk) begin
    if (rst) begin
      p_sum = 0; d_sum = 0; p_cnt = 0; d_cnt = 0;
      deck_valid = 0; wait_cnt = 0; req_run = 0;
    end else begin
      if (int'(hand_clear) + int'(p_load) + int'(d_load) > 1) overlap++;
      if (hand_clear) begin
        p_sum = 0; d_sum = 0; p_cnt = 0; d_cnt = 0;
        ev_log = {ev_log[27:0], 4'h1};
        clears++;
      end
      if (p_load) begin
        p_sum = p_sum + cards.pop_front();
        p_cnt = p_cnt + 3'd1;
        ev_log = {ev_log[27:0], 4'h2};
        p_loads++;
      end
      if (d_load) begin
        d_sum = d_sum + cards.pop_front();
        d_cnt = d_cnt + 3'd1;
        ev_log = {ev_log[27:0], 4'h3};
        d_loads++;
      end
      if (deck_req) begin
        req_run++;
        if (!deck_valid) begin
          if (wait_cnt == deck_delay) deck_valid = 1;
          else wait_cnt++;
        end
      end else begin
        if (req_run != 0) last_req_len = req_run;
        req_run = 0; deck_valid = 0; wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1; cyc; start = 0;
  endtask

  task automatic pulse_hit;
    hit = 1; cyc; hit = 0;
  endtask

  task automatic pulse_stand;
    stand = 1; cyc; stand = 0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n;
    n = 0;
    while (game_state !== st && n < budget) begin
      cyc;
      n++;
    end
    check(tag, 32'(game_state), 32'(st));
  endtask

  task automatic new_round(input int delay);
    p_loads = 0; d_loads = 0; clears = 0; ev_log = 0; deck_delay = delay;
  endtask

  initial begin
    checks = 0; failures = 0; overlap = 0; last_req_len = 0;
    start = 0; hit = 0; stand = 0; stray_valid = 0;
    new_round(0);
    rst = 1;
    repeat (3) cyc;
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_req",   32'(deck_req), 32'd0);
    check("rst_turn",  32'(turn), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_strobes", 32'({hand_clear, p_load, d_load}), 32'd0);
    rst = 0;
    cyc;

    // Round A: deal order, ignored pulses, player bust
    new_round(0);
    cards = '{5'd5, 5'd10, 5'd7, 5'd6, 5'd13};
    pulse_start;
    wait_state(3'd2, 60, "a_deal_done");
    check("a_order", ev_log, 32'h12323);
    check("a_turn_player", 32'(turn), 32'd1);
    check("a_psum", 32'(p_sum), 32'd12);
    stray_valid = 1; cyc; stray_valid = 0; cyc;
    check("a_stray_valid", 32'(p_loads + d_loads), 32'd4);
    pulse_start; cyc;
    check("a_start_ignored_state", 32'(game_state), 32'd2);
    check("a_start_ignored_clear", 32'(clears), 32'd1);
    pulse_hit;
    wait_state(3'd4, 40, "a_bust_result");
    check("a_result", 32'(result), 32'd2);
    check("a_dealer_cnt", 32'(d_cnt), 32'd2);
    check("a_turn_none", 32'(turn), 32'd0);

    // Round B: slow deck, stand, dealer draws twice
    new_round(5);
    cards = '{5'd10, 5'd4, 5'd8, 5'd6, 5'd6, 5'd4};
    pulse_start;
    check("b_start_result_none", 32'(result), 32'd0);
    wait_state(3'd2, 200, "b_deal_done");
    check("b_req_len", 32'(last_req_len), 32'd6);
    check("b_deal_loads", 32'(p_loads * 16 + d_loads), 32'h22);
    pulse_stand;
    wait_state(3'd4, 200, "b_result_state");
    check("b_dealer_draws", 32'(d_loads), 32'd4);
    check("b_dsum", 32'(d_sum), 32'd20);
    check("b_result", 32'(result), 32'd2);

    // Round C: hit and stand together at 19, dealer 19
    new_round(1);
    cards = '{5'd10, 5'd10, 5'd9, 5'd9};
    pulse_start;
    wait_state(3'd2, 100, "c_deal_done");
    hit = 1; stand = 1; cyc; hit = 0; stand = 0;
    wait_state(3'd4, 40, "c_result_state");
    check("c_no_player_draw", 32'(p_loads), 32'd2);
    check("c_result", 32'(result), 32'd3);

    // Round D: natural 21 with dealer 15
    new_round(0);
    cards = '{5'd11, 5'd10, 5'd10, 5'd5, 5'd3};
    pulse_start;
`ifdef NATURAL_BLACKJACK_EN
    wait_state(3'd4, 60, "d_natural_result_state");
    check("d_result", 32'(result), 32'd1);
    check("d_no_extra_draws", 32'(p_loads + d_loads), 32'd4);
`else
    wait_state(3'd2, 60, "d_deal_done");
    repeat (10) cyc;
    check("d_still_player", 32'(game_state), 32'd2);
    check("d_turn_player", 32'(turn), 32'd1);
    pulse_stand;
    wait_state(3'd4, 60, "d_result_state");
    check("d_dsum", 32'(d_sum), 32'd18);
    check("d_result", 32'(result), 32'd1);
`endif

    // Round E: full hand turns a hit into a stand
    new_round(0);
    cards = '{5'd2, 5'd10, 5'd2, 5'd7, 5'd2, 5'd2, 5'd2, 5'd9};
    pulse_start;
    wait_state(3'd2, 60, "e_deal_done");
    for (int i = 0; i < 3; i++) begin
      pulse_hit;
      repeat (6) cyc;
    end
    check("e_pcnt_full", 32'(p_cnt), 32'd5);
    pulse_hit;
    wait_state(3'd4, 40, "e_result_state");
    check("e_no_sixth_card", 32'(p_loads), 32'd5);
    check("e_result", 32'(result), 32'd2);

    // Round F: reset in the middle of a draw
    new_round(5);
    cards = '{5'd5, 5'd5, 5'd5, 5'd5};
    pulse_start;
    repeat (3) cyc;
    check("f_req_held", 32'(deck_req), 32'd1);
    rst = 1; cyc;
    check("f_req_dropped", 32'(deck_req), 32'd0);
    check("f_state_idle", 32'(game_state), 32'd0);
    rst = 0;
    repeat (8) cyc;
    check("f_no_load", 32'(p_loads + d_loads), 32'd0);
    check("f_result_none", 32'(result), 32'd0);

    check("strobe_exclusive", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
